// File: rtl/md_pkg.sv
// Shared opcodes, FSM states and helpers for the multiply/divide sequencer.
// Imported by md_arith and md_sequencer.
package md_pkg;

    localparam int MD_OPW = 4;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for multiple cycles.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
// Signed divide works on magnitudes so the min/-1 case cannot overflow.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   quo_u;
    logic [WIDTH-1:0]   rem_u;
    logic               neg_a;
    logic               neg_b;
    logic               b_zero;

    // Products, magnitude divide and result selection.
    always_comb begin
        prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} *
                 {{WIDTH{src_b[WIDTH-1]}}, src_b};
        prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
        neg_a  = (md_op == MD_DIV) && src_a[WIDTH-1];
        neg_b  = (md_op == MD_DIV) && src_b[WIDTH-1];
        mag_a  = neg_a ? -src_a : src_a;
        mag_b  = neg_b ? -src_b : src_b;
        b_zero = (src_b == '0);
        dvsr   = b_zero ? WIDTH'(1) : mag_b;
        quo_u  = mag_a / dvsr;
        rem_u  = mag_a % dvsr;
        res_hi = '0;
        res_lo = '0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res_lo   = (neg_a ^ neg_b) ? -quo_u : quo_u;
                res_hi   = neg_a ? -rem_u : rem_u;
                div_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency FSM, HI/LO ownership,
// mfhi/mflo read port and D-stage stall request.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             d_md,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdr
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_skip;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_zero;
    logic             launch;
    logic             commit;
    logic             wr_hi;
    logic             wr_lo;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // Next state, latency counter and register write strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && is_start_op(md_op)) begin
                    launch  = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = is_mul_op(md_op) ? CW'(MULT_CYCLES)
                                               : CW'(DIV_CYCLES);
                end
                wr_hi = start && (md_op == MD_MTHI);
                wr_lo = start && (md_op == MD_MTLO);
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result is captured at launch and held until commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_skip <= 1'b0;
        end else if (launch) begin
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_skip <= div_zero;
        end
    end

    // Architectural HI/LO: commit of a pending result or mthi/mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (!pend_skip) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else begin
            if (wr_hi) hi_q <= src_a;
            if (wr_lo) lo_q <= src_a;
        end
    end

    // Read port for mfhi/mflo.
    always_comb begin
        mdr = '0;
        if (md_op == MD_MFHI) mdr = hi_q;
        else if (md_op == MD_MFLO) mdr = lo_q;
    end

    assign busy     = (state_q == ST_RUN);
    assign md_stall = d_md & (start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a reference model.
module tb_md_sequencer;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    md_sequencer #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .d_md     (d_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .mdr      (mdr)
    );

    typedef struct {
        logic        st;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dm;
        logic        e_busy;
        logic        e_stall;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [31:0] e_mdr;
    } vec_t;

    vec_t tbl[$];

    function automatic void row(int n, logic st, logic [3:0] op,
                                logic [31:0] a, logic [31:0] b, logic dm,
                                logic eb, logic es, logic [31:0] eh,
                                logic [31:0] el, logic [31:0] em);
        vec_t v;
        v = '{st, op, a, b, dm, eb, es, eh, el, em};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic dm);
        start = st;
        md_op = op;
        src_a = a;
        src_b = b;
        d_md  = dm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural view with a remaining-cycles count.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    logic        m_skip;

    task automatic model_edge(input logic st, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !m_skip) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            m_skip = 1'b0;
            if (op == MD_MULT) begin
                sp = sa * sb;
                {m_phi, m_plo} = sp;
                m_left = 5;
            end else if (op == MD_MULTU) begin
                up = ua * ub;
                {m_phi, m_plo} = up;
                m_left = 5;
            end else if (op == MD_DIV || op == MD_DIVU) begin
                m_left = 10;
                if (b == 0) m_skip = 1'b1;
                else if (op == MD_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_plo = sq[31:0];
                    m_phi = sr[31:0];
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    m_plo = uq[31:0];
                    m_phi = ur[31:0];
                end
            end else if (op == MD_MTHI) m_hi = a;
            else if (op == MD_MTLO) m_lo = a;
        end
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 20);
            4: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic        st, dm;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        e_busy;
        logic [31:0] e_mdr;

        reset = 1'b1;
        apply(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        apply(1'b0, MD_NONE, 32'h0, 32'h0, 1'b1);
        #1;
        chk("rst_stall_nostart", md_stall, 1'b0);
        apply(1'b1, MD_MULT, 32'h3, 32'h3, 1'b1);
        #1;
        chk("rst_stall_start", md_stall, 1'b1);
        tick();
        chk("rst_hold_busy", busy, 1'b0);
        apply(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;

        // Directed table: one record per cycle.
        row(1, 1, MD_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 0, 0, 0);
        row(2, 0, MD_NONE, 0, 0, 0, 1, 0, 0, 0, 0);
        row(1, 0, MD_MFHI, 0, 0, 1, 1, 1, 0, 0, 0);
        row(2, 0, MD_NONE, 0, 0, 0, 1, 0, 0, 0, 0);
        row(1, 0, MD_MFLO, 0, 0, 0, 0, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB);
        row(1, 1, MD_MTHI, 32'h1234, 0, 0, 0, 0,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        row(1, 1, MD_MFHI, 0, 0, 1, 0, 1,
            32'h1234, 32'hFFFF_FFEB, 32'h1234);
        row(1, 0, MD_MFLO, 0, 0, 0, 0, 0,
            32'h1234, 32'hFFFF_FFEB, 32'hFFFF_FFEB);
        row(1, 1, MD_DIVU, 32'd100, 32'd7, 1, 0, 1,
            32'h1234, 32'hFFFF_FFEB, 0);
        row(10, 0, MD_NONE, 0, 0, 1, 1, 1, 32'h1234, 32'hFFFF_FFEB, 0);
        row(1, 0, MD_NONE, 0, 0, 1, 0, 0, 32'd2, 32'd14, 0);
        row(1, 1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0,
            32'd2, 32'd14, 0);
        row(10, 0, MD_NONE, 0, 0, 0, 1, 0, 32'd2, 32'd14, 0);
        row(1, 1, MD_DIV, 32'd5, 32'd0, 0, 0, 0, 0, 32'h8000_0000, 0);
        row(10, 0, MD_NONE, 0, 0, 0, 1, 0, 0, 32'h8000_0000, 0);
        row(1, 0, MD_MFLO, 0, 0, 0, 0, 0,
            0, 32'h8000_0000, 32'h8000_0000);
        row(1, 1, MD_MTLO, 32'hAA55, 0, 0, 0, 0, 0, 32'h8000_0000, 0);
        row(1, 0, MD_MFLO, 0, 0, 0, 0, 0, 0, 32'hAA55, 32'hAA55);
        row(1, 1, MD_NONE, 32'd99, 32'd99, 1, 0, 1, 0, 32'hAA55, 0);
        row(1, 0, MD_MFHI, 0, 0, 0, 0, 0, 0, 32'hAA55, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].st, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dm);
            #4;
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_stall", i), md_stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].e_hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].e_lo);
            chk($sformatf("tbl%0d_mdr", i), mdr, tbl[i].e_mdr);
            tick();
        end

        // Start while busy is ignored; first result commits.
        apply(1'b1, MD_MULTU, 32'd3, 32'd4, 1'b0);
        tick();
        apply(1'b1, MD_DIV, 32'd100, 32'd3, 1'b1);
        #4;
        chk("ign_stall", md_stall, 1'b1);
        n = 0;
        if (busy) n++;
        tick();
        apply(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            #4;
            if (!busy) break;
            n++;
            tick();
        end
        chk("ign_busy_len", n, 5);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd12);
        repeat (12) tick();
        chk("ign_no_late_lo", lo, 32'd12);
        chk("ign_no_late_busy", busy, 1'b0);

        // Async reset in the middle of a divide.
        apply(1'b1, MD_MTLO, 32'h55, 32'h0, 1'b0);
        tick();
        apply(1'b1, MD_DIV, 32'd7, 32'd2, 1'b0);
        tick();
        apply(1'b0, MD_NONE, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rmid_busy_before", busy, 1'b1);
        chk("rmid_lo_before", lo, 32'h55);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_hi", hi, 32'h0);
        chk("rmid_lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("rmid_after_busy", busy, 1'b0);
        chk("rmid_after_hi", hi, 32'h0);
        chk("rmid_after_lo", lo, 32'h0);

        // Randomized run against the reference model.
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_skip = 0;
        for (int c = 0; c < 400; c++) begin
            st = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 8));
            a  = pick_val();
            b  = pick_val();
            dm = 1'($urandom_range(0, 1));
            apply(st, op, a, b, dm);
            #4;
            e_busy = (m_left > 0);
            e_mdr  = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'h0;
            chk("rnd_busy", busy, e_busy);
            chk("rnd_stall", md_stall, dm & (st | e_busy));
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);
            chk("rnd_mdr", mdr, e_mdr);
            model_edge(st, op, a, b);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
